// File: rtl/rca_16bit_pkg.sv
// Shared width constant and result payload for the 16-bit ripple-carry adder.
package rca_16bit_pkg;

    localparam int unsigned ADDER_W = 16;

    typedef struct packed {
        logic               cout;
        logic [ADDER_W-1:0] sum;
    } add_res_t;

endpackage

// File: rtl/rca_16bit_full_adder.sv
// One-bit full adder; the ripple stage of rca_16bit.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic prop;

    assign prop = a ^ b;
    assign sum  = prop ^ cin;
    assign cout = (a & b) | (cin & prop);

endmodule

// File: rtl/rca_16bit.sv
// 16-bit ripple-carry adder with a registered {cout, sum}; one-cycle latency.
module rca_16bit
    import rca_16bit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDER_W-1:0] a,
    input  logic [ADDER_W-1:0] b,
    input  logic               cin,
    output logic [ADDER_W-1:0] sum,
    output logic               cout
);

    logic [ADDER_W:0]   carry;
    logic [ADDER_W-1:0] s;
    add_res_t           res_d;
    add_res_t           res_q;

    assign carry[0] = cin;

    // Carry chain: each stage's carry-out feeds the next stage directly.
    for (genvar i = 0; i < ADDER_W; i++) begin : g_stage
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (s[i]),
            .cout (carry[i+1])
        );
    end

    always_comb begin
        res_d      = '0;
        res_d.sum  = s;
        res_d.cout = carry[ADDER_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign sum  = res_q.sum;
    assign cout = res_q.cout;

endmodule

// File: tb/tb_rca_16bit.sv
// Scoreboard bench for rca_16bit: driver queues expected results, monitor checks each cycle.
module tb_rca_16bit;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [16:0] exp;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    rca_16bit dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string tag, input logic [16:0] act, input logic [16:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got {cout,sum}=%05h, expected %05h at %0t", tag, act, exp, $time);
        end
    endfunction

    // Monitor: one result per rising edge once the driver has queued expectations.
    exp_t mon_e;
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check(mon_e.tag, {cout, sum}, mon_e.exp);
        end
    end

    // Drive one operation at the falling edge; rst changes here act asynchronously mid-cycle.
    task automatic drive(input string tag, input logic r, input logic [15:0] av,
                         input logic [15:0] bv, input logic c, input logic [16:0] exp_sum);
        exp_t  e;
        logic  prev_rst;
        @(negedge clk);
        prev_rst = rst;
        rst = r;
        a   = av;
        b   = bv;
        cin = c;
        e.exp = r ? 17'h0_0000 : exp_sum;
        e.tag = tag;
        exp_q.push_back(e);
        if (r && !prev_rst) begin
            #1;
            check({tag, "_async_rst"}, {cout, sum}, 17'h0_0000);
        end
    endtask

    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rr;
    logic [16:0] ref_v;

    initial begin
        rst = 1'b0;
        a   = 16'h0;
        b   = 16'h0;
        cin = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("reset_initial", {cout, sum}, 17'h0_0000);

        // Held in reset with busy inputs: outputs stay zero across edges.
        drive("rst_hold0", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 17'h0);
        drive("rst_hold1", 1'b1, 16'h1234, 16'hABCD, 1'b0, 17'h0);

        // Directed vectors, issued back to back.
        drive("ff3f_5555",      1'b0, 16'hFF3F, 16'h5555, 1'b0, 17'h1_5494);
        drive("cf39_30c6_c0",   1'b0, 16'hCF39, 16'h30C6, 1'b0, 17'h0_FFFF);
        drive("cf39_30c6_c1",   1'b0, 16'hCF39, 16'h30C6, 1'b1, 17'h1_0000);
        drive("a8a9_5757",      1'b0, 16'hA8A9, 16'h5757, 1'b0, 17'h1_0000);
        drive("ffff_0000_c1",   1'b0, 16'hFFFF, 16'h0000, 1'b1, 17'h1_0000);
        drive("zero",           1'b0, 16'h0000, 16'h0000, 1'b0, 17'h0_0000);
        drive("one_plus_cin",   1'b0, 16'h0001, 16'h0000, 1'b1, 17'h0_0002);
        drive("max_max_c1",     1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF);
        drive("b2b_0",          1'b0, 16'h1234, 16'h4321, 1'b0, 17'h0_5555);
        drive("b2b_1",          1'b0, 16'h8000, 16'h8000, 1'b0, 17'h1_0000);
        drive("b2b_2",          1'b0, 16'h7FFF, 16'h0001, 1'b0, 17'h0_8000);
        drive("pre_rst",        1'b0, 16'h00F0, 16'h000F, 1'b0, 17'h0_00FF);

        // Reset while a nonzero result is on the outputs, then release.
        drive("mid_rst",        1'b1, 16'hAAAA, 16'h5555, 1'b1, 17'h0);
        drive("post_rst",       1'b0, 16'h0F0F, 16'hF0F0, 1'b0, 17'h0_FFFF);

        // Random vectors with sporadic reset pulses.
        for (int i = 0; i < 10000; i++) begin
            ra    = 16'($urandom);
            rb    = 16'($urandom);
            rc    = 1'($urandom_range(0, 1));
            rr    = ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0;
            ref_v = {1'b0, ra} + {1'b0, rb} + 17'(rc);
            drive("random", rr, ra, rb, rc, ref_v);
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
